// File: rtl/pattern_seq_if.sv
// pattern_seq_if: command handshake bundle between a controller (master) and pattern_seq (slave)
interface pattern_seq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_pattern;
  logic       cmd_auto;
  logic [7:0] cmd_dwell;
  modport master (output cmd_valid, cmd_pattern, cmd_auto, cmd_dwell, input cmd_ready);
  modport slave  (input cmd_valid, cmd_pattern, cmd_auto, cmd_dwell, output cmd_ready);
endinterface

// File: rtl/pattern_seq.sv
// pattern_seq: frame-synchronous test-pattern selector; auto-cycle mode is built only with PATTERN_SEQ_AUTO_EN
module pattern_seq #(
  parameter logic [7:0] MAX_PATTERN   = 8'd5,
  parameter logic [7:0] RESET_PATTERN = 8'd5
) (
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic         vn_in,
  pattern_seq_if.slave cmd,
  output logic [7:0]   pattern,
  output logic         switch_pulse,
  output logic         busy
);
`ifdef PATTERN_SEQ_AUTO_EN
  typedef enum logic [1:0] {MANUAL = 2'd0, PENDING = 2'd1, AUTO = 2'd2} state_t;
`else
  typedef enum logic [1:0] {MANUAL = 2'd0, PENDING = 2'd1} state_t;
`endif
  state_t     r_state, w_state_n;
  logic       r_vn_d, r_switch;
  logic [7:0] r_pattern, w_pattern_n, r_code, w_code_n, w_clamp;
  logic       w_fb, w_xfer, w_load;
`ifdef PATTERN_SEQ_AUTO_EN
  logic       r_auto, w_auto_n;
  logic [7:0] r_dwell, w_dwell_n, r_cnt, w_cnt_n;
`else
  logic       w_unused;
  assign w_unused = ^{cmd.cmd_auto, cmd.cmd_dwell};
`endif
  assign w_fb          = r_vn_d & ~vn_in;
  assign w_xfer        = cmd.cmd_valid & (r_state != PENDING);
  assign w_clamp       = (cmd.cmd_pattern > MAX_PATTERN) ? MAX_PATTERN : cmd.cmd_pattern;
  assign busy          = (r_state == PENDING);
  assign cmd.cmd_ready = ~busy;
  assign pattern       = r_pattern;
  assign switch_pulse  = r_switch;
  // Next-state logic: a new command always wins over the frame boundary, so a command accepted on fb waits a full frame
  always_comb begin
    w_state_n   = r_state;
    w_pattern_n = r_pattern;
    w_code_n    = r_code;
    w_load      = 1'b0;
`ifdef PATTERN_SEQ_AUTO_EN
    w_auto_n    = r_auto;
    w_dwell_n   = r_dwell;
    w_cnt_n     = r_cnt;
`endif
    if (w_xfer) begin
      w_state_n = PENDING;
`ifdef PATTERN_SEQ_AUTO_EN
      w_auto_n  = cmd.cmd_auto;
      if (cmd.cmd_auto) w_dwell_n = (cmd.cmd_dwell == 8'd0) ? 8'd1 : cmd.cmd_dwell;
      else w_code_n = w_clamp;
`else
      w_code_n  = w_clamp;
`endif
    end else if (w_fb && r_state == PENDING) begin
      w_load = 1'b1;
`ifdef PATTERN_SEQ_AUTO_EN
      if (r_auto) begin
        w_pattern_n = 8'd0;
        w_cnt_n     = r_dwell;
        w_state_n   = AUTO;
      end else begin
        w_pattern_n = r_code;
        w_state_n   = MANUAL;
      end
`else
      w_pattern_n = r_code;
      w_state_n   = MANUAL;
`endif
    end
`ifdef PATTERN_SEQ_AUTO_EN
    else if (w_fb && r_state == AUTO) begin
      if (r_cnt == 8'd1) begin
        w_load      = 1'b1;
        w_pattern_n = (r_pattern >= MAX_PATTERN) ? 8'd0 : r_pattern + 8'd1;
        w_cnt_n     = r_dwell;
      end else begin
        w_cnt_n     = r_cnt - 8'd1;
      end
    end
`endif
  end
  // State register; switch strobe is the registered load flag so it coincides with the new pattern
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= MANUAL;
      r_vn_d    <= 1'b1;
      r_pattern <= RESET_PATTERN;
      r_code    <= 8'd0;
      r_switch  <= 1'b0;
`ifdef PATTERN_SEQ_AUTO_EN
      r_auto    <= 1'b0;
      r_dwell   <= 8'd0;
      r_cnt     <= 8'd0;
`endif
    end else begin
      r_state   <= w_state_n;
      r_vn_d    <= vn_in;
      r_pattern <= w_pattern_n;
      r_code    <= w_code_n;
      r_switch  <= w_load;
`ifdef PATTERN_SEQ_AUTO_EN
      r_auto    <= w_auto_n;
      r_dwell   <= w_dwell_n;
      r_cnt     <= w_cnt_n;
`endif
    end
  end
endmodule
